vo_pattern_gen: RTL and testbench
=================================

Name: vo_pattern_gen

Overview:
- Upstream pixel source for the video output stage; produces a frame-ordered RGB stream with req/eol/eof markers.
- Generates test patterns (colour bars, checkerboard, horizontal gradient, solid colour), frame-locked to a start pulse from the timing side.
- Used for bring-up and as the fallback source when no framebuffer is present.
- Pixel packing matches the output stage: R in [7:0], G in [15:8], B in [23:16].

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 1024, active lines per frame.
- CHECK_SHIFT, 5, checkerboard square size is 2^CHECK_SHIFT pixels.
- SOLID_RGB, 24'hFF_FF_FF, colour for mode 3 (same packing).

Ports:
- vo_clk  in  1  pixel clock.
- vo_reset  in  1  synchronous active-high reset.
- frame_start  in  1  single-cycle pulse; starts or restarts a frame.
- mode  in  2  0 bars, 1 checker, 2 gradient, 3 solid; sampled only on frame_start.
- pix_ready  in  1  downstream accepts the current pixel.
- pix_req  out  1  pixel valid.
- pix_eol  out  1  current pixel is the last of its line.
- pix_eof  out  1  current pixel is the last of the frame.
- pix_pixel  out  24  RGB pixel.
- pix_vsync  out  1  high on the first pixel of a frame while pix_req is high.
- frame_cnt  out  8  completed frames; wraps 255 -> 0.

Behaviour:
- Clock and reset:
  - One clock, vo_clk.
  - Reset is synchronous and active-high on vo_reset.
  - Reset values: all outputs 0, state IDLE, x = y = 0, latched mode = 0, frame_cnt = 0.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE: pix_req = 0. On frame_start -> ACTIVE, with x = y = 0 and mode latched.
  - ACTIVE: pix_req = 1.
  - A transfer occurs on a cycle with pix_req && pix_ready.
  - On a transfer, x increments. At x == H_ACTIVE-1, x -> 0 and y increments.
  - The transfer of (H_ACTIVE-1, V_ACTIVE-1) -> DONE, and frame_cnt increments in the same cycle.
  - DONE: pix_req = 0. On frame_start -> ACTIVE with new frame setup.
- Handshake:
  - While pix_req = 1 and pix_ready = 0, pix_pixel, pix_eol, pix_eof and pix_vsync hold stable.
  - pix_req never deasserts without a transfer, except on reset or on a frame_start restart.
- Output registers:
  - All outputs are registered.
  - Data for coordinate (x,y) is present on the same cycle pix_req shows that coordinate.
  - Next-pixel data is computed one cycle ahead, so back-to-back transfers run at one pixel per clock.
- Markers:
  - pix_eol = (x == H_ACTIVE-1).
  - pix_eof = (x == H_ACTIVE-1 && y == V_ACTIVE-1).
  - pix_vsync = (x == 0 && y == 0).
- Patterns:
  - bars: 8 vertical bars, each H_ACTIVE/8 wide (H_ACTIVE divisible by 8).
    - Colour order: white, yellow, cyan, green, magenta, red, blue, black; components are 0 or FF.
    - Bar index is kept by a width counter that resets at x = 0; no divider.
  - checker: pixel is white if (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) else black.
  - gradient: R = G = B = x[7:0].
  - solid: SOLID_RGB.
- Boundary conditions:
  - frame_start during ACTIVE: abort the current frame. Next cycle shows (0,0) with pix_vsync = 1 and the new mode. frame_cnt does not increment.
  - frame_start on the same cycle as the final-pixel transfer: frame_cnt increments, and the state goes to ACTIVE at (0,0), not DONE.
  - Mode changes outside frame_start have no effect.
  - Reset mid-frame: back to IDLE next cycle, regardless of pix_ready.
- Counter widths: x is $clog2(H_ACTIVE) bits, y is $clog2(V_ACTIVE) bits.

Optional Feature:
- Macro: VO_PATTERN_SCROLL_EN.
- Defined: pattern x-coordinate = x + frame_cnt, used for bars, checker and gradient.
  - The add is modulo H_ACTIVE for bars; plain bit-truncated for checker and gradient.
  - Markers are unaffected.
- Undefined: no offset; frame_cnt is still output.

Decomposition:
- Shared video package holds:
  - mode encodings: PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_SOLID;
  - FSM state typedef;
  - the 8-entry bar colour constant table;
  - RGB packing field offsets, shared with the output stage.
- One natural sub-module, vo_pattern_pixel: combinational pattern lookup from (mode, x, y, bar index) to a 24-bit colour. The top level holds the FSM, counters and handshake.

Test Plan:
- Reset, then frame_start with mode=0, pix_ready=1 at H_ACTIVE=16, V_ACTIVE=4 -> 64 consecutive transfers.
  - Pixels 0,1 = FFFFFF; pixels 2,3 = 00FFFF (yellow).
  - pix_eol at x=15 of each line; pix_eof only on transfer 64.
  - pix_vsync only on transfer 1; frame_cnt becomes 1; state DONE with pix_req=0.
- Mode=2 with pix_ready toggling 1,0,0,1 -> data held stable across stalls; gradient values 00,01,02 appear in order with no skip or duplicate.
- frame_start at pixel (5,2) of a running frame, mode=1 -> next cycle pix_req=1, x=y=0, pix_vsync=1; frame_cnt unchanged.
- frame_start coincident with the final transfer -> frame_cnt increments; next cycle shows (0,0) with no IDLE/DONE gap.
- vo_reset asserted mid-line with pix_ready=0 -> next cycle all outputs 0; a following frame_start begins at (0,0).
- With VO_PATTERN_SCROLL_EN, gradient frame 3 (frame_cnt=3) -> first pixel 030303.

Source files
------------

// File: rtl/vo_pattern_gen_pkg.sv
// Shared video definitions for the pattern generator and the output stage.
//   - pattern mode encodings (PAT_*)
//   - pattern generator FSM state type
//   - 8-entry colour-bar table
//   - RGB packing: R in [7:0], G in [15:8], B in [23:16]
package vo_pattern_gen_pkg;

  localparam int RGB_W = 24;
  localparam int R_LSB = 0;
  localparam int G_LSB = 8;
  localparam int B_LSB = 16;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } vo_state_e;

  function automatic logic [RGB_W-1:0] pack_rgb(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    logic [RGB_W-1:0] v;
    v = '0;
    v[R_LSB +: 8] = r;
    v[G_LSB +: 8] = g;
    v[B_LSB +: 8] = b;
    return v;
  endfunction

  // Index 0 is the leftmost bar.
  localparam logic [7:0][RGB_W-1:0] BAR_RGB = {
    24'h00_00_00,  // 7 black
    24'hFF_00_00,  // 6 blue
    24'h00_00_FF,  // 5 red
    24'hFF_00_FF,  // 4 magenta
    24'h00_FF_00,  // 3 green
    24'hFF_FF_00,  // 2 cyan
    24'h00_FF_FF,  // 1 yellow
    24'hFF_FF_FF   // 0 white
  };

endpackage

// File: rtl/vo_pattern_gen_if.sv
// Pixel stream between the pattern generator (master) and the output stage (slave).
//   pix_req    pixel valid
//   pix_ready  sink accepts the current pixel
//   pix_eol    last pixel of a line
//   pix_eof    last pixel of a frame
//   pix_vsync  first pixel of a frame
//   pix_pixel  packed RGB
interface vo_pattern_gen_if;
  logic                                pix_req;
  logic                                pix_ready;
  logic                                pix_eol;
  logic                                pix_eof;
  logic                                pix_vsync;
  logic [vo_pattern_gen_pkg::RGB_W-1:0] pix_pixel;

  modport master (
    output pix_req, pix_eol, pix_eof, pix_vsync, pix_pixel,
    input  pix_ready
  );

  modport slave (
    input  pix_req, pix_eol, pix_eof, pix_vsync, pix_pixel,
    output pix_ready
  );
endinterface

// File: rtl/vo_pattern_pixel.sv
// Combinational pattern lookup.
//   mode_i  pattern select
//   px_i    pattern x-coordinate (checker, gradient)
//   y_i     line number
//   bar_i   colour-bar index
//   rgb_o   packed RGB colour
module vo_pattern_pixel
  import vo_pattern_gen_pkg::*;
#(
  parameter int               XW          = 11,
  parameter int               YW          = 10,
  parameter int               CHECK_SHIFT = 5,
  parameter logic [RGB_W-1:0] SOLID_RGB   = 24'hFF_FF_FF
) (
  input  pat_mode_e        mode_i,
  input  logic [XW-1:0]    px_i,
  input  logic [YW-1:0]    y_i,
  input  logic [2:0]       bar_i,
  output logic [RGB_W-1:0] rgb_o
);
  logic       chk_x;
  logic       chk_y;
  logic [7:0] grad;

  // Shift form keeps CHECK_SHIFT legal even when it exceeds the counter width.
  assign chk_x = |((px_i >> CHECK_SHIFT) & XW'(1));
  assign chk_y = |((y_i >> CHECK_SHIFT) & YW'(1));
  assign grad  = 8'(px_i);

  always_comb begin
    rgb_o = '0;
    unique case (mode_i)
      PAT_BARS:  rgb_o = BAR_RGB[bar_i];
      PAT_CHECK: rgb_o = (chk_x ^ chk_y) ? 24'hFF_FF_FF : 24'h00_00_00;
      PAT_GRAD:  rgb_o = pack_rgb(grad, grad, grad);
      PAT_SOLID: rgb_o = SOLID_RGB;
      default:   rgb_o = '0;
    endcase
  end
endmodule

// File: rtl/vo_pattern_gen.sv
// Frame-locked test-pattern source (bars, checker, gradient, solid).
//   vo_clk, vo_reset  pixel clock, synchronous active-high reset
//   frame_start       starts/restarts a frame, latches mode
//   mode              pattern select, sampled on frame_start only
//   pix               pixel stream master (req/ready, eol/eof/vsync, pixel)
//   frame_cnt         completed frames, wraps
// Optional build macro VO_PATTERN_SCROLL_EN: offsets the pattern x-coordinate
// by frame_cnt (modulo H_ACTIVE for bars, truncated for checker/gradient).
//
// state  | meaning
// IDLE   | after reset, no frame yet, pix_req low
// ACTIVE | presenting pixels, pix_req high
// DONE   | frame complete, waiting for frame_start
module vo_pattern_gen
  import vo_pattern_gen_pkg::*;
#(
  parameter int               H_ACTIVE    = 1280,
  parameter int               V_ACTIVE    = 1024,
  parameter int               CHECK_SHIFT = 5,
  parameter logic [RGB_W-1:0] SOLID_RGB   = 24'hFF_FF_FF
) (
  input  logic             vo_clk,
  input  logic             vo_reset,
  input  logic             frame_start,
  input  logic [1:0]       mode,
  vo_pattern_gen_if.master pix,
  output logic [7:0]       frame_cnt
);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BAR_W - 1);

  // Bar tracking: pattern x, bar index, and a down-counter of pixels left in the bar.
  typedef struct packed {
    logic [XW-1:0] sx;
    logic [2:0]    bar;
    logic [CW-1:0] cnt;
  } bpos_t;
  localparam bpos_t BPOS_ZERO = '{sx: '0, bar: 3'd0, cnt: CNT_LOAD};

  function automatic bpos_t bpos_step(input bpos_t p);
    bpos_t n;
    n = p;
    if (p.sx == X_LAST) begin
      n = BPOS_ZERO;
    end else begin
      n.sx = p.sx + XW'(1);
      if (p.cnt == '0) begin
        n.bar = p.bar + 3'd1;
        n.cnt = CNT_LOAD;
      end else begin
        n.cnt = p.cnt - CW'(1);
      end
    end
    return n;
  endfunction

  vo_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  pat_mode_e        mode_q, mode_d;
  logic [7:0]       fcnt_q, fcnt_d;
  bpos_t            pos_q, pos_d;
  bpos_t            start_pos;
  logic [XW-1:0]    px;
  logic             req_q, req_d, eol_q, eol_d, eof_q, eof_d, vsync_q, vsync_d;
  logic [RGB_W-1:0] pixel_q, pixel_d, pat_rgb;
  logic             xfer, at_eol, at_last, frame_done;

  assign xfer       = req_q & pix.pix_ready;
  assign at_eol     = (x_q == X_LAST);
  assign at_last    = at_eol & (y_q == Y_LAST);
  assign frame_done = xfer & at_last;
  assign fcnt_d     = frame_done ? fcnt_q + 8'd1 : fcnt_q;

`ifdef VO_PATTERN_SCROLL_EN
  // Bar position of frame_cnt mod H_ACTIVE, stepped alongside frame_cnt so the
  // per-frame starting bar needs no divider.
  bpos_t off_q, off_d;

  always_comb begin
    off_d = off_q;
    if (frame_done) off_d = (fcnt_q == 8'hFF) ? BPOS_ZERO : bpos_step(off_q);
  end

  always_ff @(posedge vo_clk) begin
    if (vo_reset) off_q <= BPOS_ZERO;
    else          off_q <= off_d;
  end

  assign start_pos = off_d;
  assign px        = x_d + XW'(fcnt_d);
`else
  assign start_pos = BPOS_ZERO;
  assign px        = x_d;
`endif

  // State register
  always_ff @(posedge vo_clk) begin
    if (vo_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (frame_start) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (frame_start)     state_d = ST_ACTIVE;
        else if (frame_done) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Coordinate of the pixel to present next cycle.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    pos_d  = pos_q;
    if (frame_start) begin
      x_d    = '0;
      y_d    = '0;
      mode_d = pat_mode_e'(mode);
      pos_d  = start_pos;
    end else if (xfer && !at_last) begin
      if (at_eol) begin
        x_d   = '0;
        y_d   = y_q + YW'(1);
        pos_d = start_pos;
      end else begin
        x_d   = x_q + XW'(1);
        pos_d = bpos_step(pos_q);
      end
    end
  end

  vo_pattern_pixel #(
    .XW          (XW),
    .YW          (YW),
    .CHECK_SHIFT (CHECK_SHIFT),
    .SOLID_RGB   (SOLID_RGB)
  ) u_pixel (
    .mode_i (mode_d),
    .px_i   (px),
    .y_i    (y_d),
    .bar_i  (pos_d.bar),
    .rgb_o  (pat_rgb)
  );

  // Outputs, computed from next-cycle coordinate and registered.
  always_comb begin
    req_d   = (state_d == ST_ACTIVE);
    eol_d   = req_d & (x_d == X_LAST);
    eof_d   = eol_d & (y_d == Y_LAST);
    vsync_d = req_d & (x_d == '0) & (y_d == '0);
    pixel_d = req_d ? pat_rgb : '0;
  end

  always_ff @(posedge vo_clk) begin
    if (vo_reset) begin
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= PAT_BARS;
      fcnt_q  <= '0;
      pos_q   <= BPOS_ZERO;
      req_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      vsync_q <= 1'b0;
      pixel_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      pos_q   <= pos_d;
      req_q   <= req_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      vsync_q <= vsync_d;
      pixel_q <= pixel_d;
    end
  end

  assign pix.pix_req   = req_q;
  assign pix.pix_eol   = eol_q;
  assign pix.pix_eof   = eof_q;
  assign pix.pix_vsync = vsync_q;
  assign pix.pix_pixel = pixel_q;
  assign frame_cnt     = fcnt_q;
endmodule

// File: tb/tb_vo_pattern_gen.sv
module tb_vo_pattern_gen;
  localparam int          H     = 16;
  localparam int          V     = 4;
  localparam int          CS    = 2;
  localparam int          XW    = $clog2(H);
  localparam logic [23:0] SOLID = 24'h12_34_56;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                       24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

  logic       vo_clk;
  logic       vo_reset;
  logic       frame_start;
  logic [1:0] mode;
  logic [7:0] frame_cnt;

  vo_pattern_gen_if ifc();

  vo_pattern_gen #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .CHECK_SHIFT (CS),
    .SOLID_RGB   (SOLID)
  ) dut (
    .vo_clk      (vo_clk),
    .vo_reset    (vo_reset),
    .frame_start (frame_start),
    .mode        (mode),
    .pix         (ifc),
    .frame_cnt   (frame_cnt)
  );

  initial vo_clk = 1'b0;
  always #5 vo_clk = ~vo_clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: is a pixel being offered, which one, and in which frame.
  bit m_req  = 0;
  int m_x    = 0;
  int m_y    = 0;
  int m_mode = 0;
  int m_fcnt = 0;

  typedef struct {
    logic [23:0] px;
    logic        eol;
    logic        eof;
    logic        vsync;
  } xfer_t;
  xfer_t xlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int md, input int x, input int y, input int fc);
    int pmod, ptr;
`ifdef VO_PATTERN_SCROLL_EN
    pmod = (x + fc) % H;
    ptr  = (x + fc) % (1 << XW);
`else
    pmod = x + 0 * fc;
    ptr  = x;
`endif
    case (md)
      0:       return BARS[pmod / (H / 8)];
      1:       return (((ptr >> CS) ^ (y >> CS)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      2:       return {ptr[7:0], ptr[7:0], ptr[7:0]};
      default: return SOLID;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit fs, input logic [1:0] md, input bit rdy);
    bit xf, fin;
    if (rst) begin
      m_req = 0; m_x = 0; m_y = 0; m_mode = 0; m_fcnt = 0;
    end else begin
      xf  = m_req && rdy;
      fin = xf && (m_x == H - 1) && (m_y == V - 1);
      if (fin) m_fcnt = (m_fcnt + 1) % 256;
      if (fs) begin
        m_req = 1; m_x = 0; m_y = 0; m_mode = int'(md);
      end else if (fin) begin
        m_req = 0;
      end else if (xf) begin
        m_x++;
        if (m_x == H) begin
          m_x = 0;
          m_y++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("req",       32'(ifc.pix_req),   32'(m_req));
    check("eol",       32'(ifc.pix_eol),   32'(m_req && m_x == H - 1));
    check("eof",       32'(ifc.pix_eof),   32'(m_req && m_x == H - 1 && m_y == V - 1));
    check("vsync",     32'(ifc.pix_vsync), 32'(m_req && m_x == 0 && m_y == 0));
    check("pixel",     32'(ifc.pix_pixel), m_req ? 32'(exp_pix(m_mode, m_x, m_y, m_fcnt)) : 32'd0);
    check("frame_cnt", 32'(frame_cnt),     32'(m_fcnt));
  endtask

  // One clock: drive inputs, log any transfer, advance the model, check at negedge.
  task automatic tick(input bit rst, input bit fs, input logic [1:0] md, input bit rdy);
    xfer_t e;
    vo_reset      = rst;
    frame_start   = fs;
    mode          = md;
    ifc.pix_ready = rdy;
    #1;
    if (ifc.pix_req && rdy && !rst) begin
      e.px = ifc.pix_pixel; e.eol = ifc.pix_eol; e.eof = ifc.pix_eof; e.vsync = ifc.pix_vsync;
      xlog.push_back(e);
    end
    @(posedge vo_clk);
    model_step(rst, fs, md, rdy);
    @(negedge vo_clk);
    compare_all();
  endtask

  localparam bit STALL_PAT [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    vo_reset = 1'b1; frame_start = 1'b0; mode = 2'd0; ifc.pix_ready = 1'b0;
    @(negedge vo_clk);
    tick(1, 0, 2'd0, 0);
    tick(1, 0, 2'd0, 0);
    check("reset_req", 32'(ifc.pix_req), 32'd0);
    check("reset_fcnt", 32'(frame_cnt), 32'd0);

    // Full bars frame, back-to-back.
    tick(0, 1, 2'd0, 1);
    xlog.delete();
    for (int i = 0; i < H * V; i++) tick(0, 0, 2'd1, 1);
    check("t1_count", 32'(xlog.size()), 32'(H * V));
    if (xlog.size() == H * V) begin
      check("t1_px0", 32'(xlog[0].px), 32'hFFFFFF);
      check("t1_px1", 32'(xlog[1].px), 32'hFFFFFF);
      check("t1_px2", 32'(xlog[2].px), 32'h00FFFF);
      check("t1_px3", 32'(xlog[3].px), 32'h00FFFF);
      for (int i = 0; i < H * V; i++) begin
        check("t1_eol",   32'(xlog[i].eol),   32'((i % H) == H - 1));
        check("t1_eof",   32'(xlog[i].eof),   32'(i == H * V - 1));
        check("t1_vsync", 32'(xlog[i].vsync), 32'(i == 0));
      end
    end
    check("t1_fcnt", 32'(frame_cnt), 32'd1);
    check("t1_done_req", 32'(ifc.pix_req), 32'd0);

    // Gradient with stalls.
    tick(0, 1, 2'd2, 0);
    xlog.delete();
    for (int i = 0; i < 12; i++) tick(0, 0, 2'd0, STALL_PAT[i % 4]);
    check("t2_count", 32'(xlog.size()), 32'd6);
    if (xlog.size() >= 3) begin
      check("t2_g0", 32'(xlog[0].px), 32'h000000);
      check("t2_g1", 32'(xlog[1].px), 32'h010101);
      check("t2_g2", 32'(xlog[2].px), 32'h020202);
    end

    // Abort at (5,2) of a solid frame, restart in checker.
    tick(0, 1, 2'd3, 0);
    for (int i = 0; i < 2 * H + 5; i++) tick(0, 0, 2'd2, 1);
    check("t3_solid", 32'(ifc.pix_pixel), 32'(SOLID));
    tick(0, 1, 2'd1, 0);
    check("t3_req",   32'(ifc.pix_req),   32'd1);
    check("t3_vsync", 32'(ifc.pix_vsync), 32'd1);
    check("t3_fcnt",  32'(frame_cnt),     32'd1);
    check("t3_px",    32'(ifc.pix_pixel), 32'h000000);

    // Restart coincident with the final transfer.
    for (int i = 0; i < H * V - 1; i++) tick(0, 0, 2'd3, 1);
    check("t4_eof", 32'(ifc.pix_eof), 32'd1);
    tick(0, 1, 2'd0, 1);
    check("t4_fcnt",  32'(frame_cnt),     32'd2);
    check("t4_req",   32'(ifc.pix_req),   32'd1);
    check("t4_vsync", 32'(ifc.pix_vsync), 32'd1);
    check("t4_px",    32'(ifc.pix_pixel), 32'hFFFFFF);

    // Randomised traffic: stalls, restarts, ignored mode changes, rare resets.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(999) == 0, $urandom_range(59) == 0,
           2'($urandom_range(3)), $urandom_range(99) < 70);
    end

    // Reset mid-line with the sink stalled.
    tick(0, 1, 2'd2, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 2'd0, 1);
    tick(1, 0, 2'd0, 0);
    check("t5_req",   32'(ifc.pix_req),   32'd0);
    check("t5_px",    32'(ifc.pix_pixel), 32'd0);
    check("t5_vsync", 32'(ifc.pix_vsync), 32'd0);
    check("t5_fcnt",  32'(frame_cnt),     32'd0);
    tick(0, 1, 2'd0, 0);
    check("t5_restart_vsync", 32'(ifc.pix_vsync), 32'd1);
    check("t5_restart_req",   32'(ifc.pix_req),   32'd1);

    // Three complete frames, then a gradient frame with frame_cnt = 3.
    for (int i = 0; i < H * V; i++) tick(0, 0, 2'd0, 1);
    for (int f = 0; f < 2; f++) begin
      tick(0, 1, 2'd0, 0);
      for (int i = 0; i < H * V; i++) tick(0, 0, 2'd0, 1);
    end
    tick(0, 1, 2'd2, 0);
    check("t6_fcnt", 32'(frame_cnt), 32'd3);
`ifdef VO_PATTERN_SCROLL_EN
    check("t6_scroll_px", 32'(ifc.pix_pixel), 32'h030303);
`else
    check("t6_noscroll_px", 32'(ifc.pix_pixel), 32'h000000);
`endif
    for (int i = 0; i < 8; i++) tick(0, 0, 2'd1, i[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
